// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues one instruction-memory read per PC value,
// captures the returned word into the IF/ID register, and tells the program
// counter when it may advance. A one-entry skid buffer absorbs decode stalls
// and a flush path discards wrong-path work after a taken redirect.
module instruction_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic        pc_hold,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  input  logic        stall,
  input  logic        flush,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus_4,
  output logic [25:0] jump_address,
  output logic [15:0] branch_offset,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // ISSUE : launch a request for the current pc
  // FETCH : request outstanding, waiting for imem_ready
  // SKID  : returned word parked in the skid buffer while decode stalls
  // DROP  : request outstanding but flushed; its data will be thrown away
  // FAULT : misaligned pc seen, fetch stopped until reset
  typedef enum logic [2:0] {
    ISSUE,
    FETCH,
    SKID,
    DROP,
    FAULT
  } state_t;

  state_t      state_q, state_d;
  logic        req_d;
  logic [31:0] addr_d;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] instr_pc_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        fault_d;
  logic        load_fetch;
  logic        load_skid;

  // The PC may only move on the edge where a fetched word is accepted.
  assign pc_hold = !((state_q == FETCH) && imem_ready && !flush);

  // Field taps decoded straight from the IF/ID register.
  assign instr_pc_plus_4 = instr_pc + 32'd4;
  assign jump_address    = instr[25:0];
  assign branch_offset   = instr[15:0];

  // Next-state logic for the fetch FSM, the request port and the IF/ID register.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    state_d    = state_q;
    req_d      = imem_req;
    addr_d     = imem_addr;
    valid_d    = instr_valid;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    fault_d    = fetch_fault;
    load_fetch = 1'b0;
    load_skid  = 1'b0;

    unique case (state_q)
      ISSUE: begin
        // During a redirect the pc input is still the stale one, so wait a
        // cycle for the redirected value instead of fetching the wrong path.
        if (flush) begin
          state_d = ISSUE;
        end else if (pc[1:0] != 2'b00) begin
          fault_d = 1'b1;
          state_d = FAULT;
        end else begin
          addr_d  = pc;
          req_d   = 1'b1;
          state_d = FETCH;
        end
      end

      FETCH: begin
        if (imem_ready) begin
          req_d   = 1'b0;
          state_d = ISSUE;
          if (!flush) begin
            if (!instr_valid || !stall) begin
              load_fetch = 1'b1;
            end else begin
              // Decode is holding a live word: park the new one.
              skid_d    = imem_rdata;
              skid_pc_d = imem_addr;
              state_d   = SKID;
            end
          end
        end else if (flush) begin
          // The memory must still complete this request; keep it asserted.
          state_d = DROP;
        end
      end

      SKID: begin
        if (flush) begin
          state_d = ISSUE;
        end else if (!stall) begin
          load_skid = 1'b1;
          state_d   = ISSUE;
        end
      end

      DROP: begin
        if (imem_ready) begin
          req_d   = 1'b0;
          state_d = ISSUE;
        end
      end

      FAULT: begin
        req_d = 1'b0;
      end

      default: begin
        state_d = ISSUE;
        req_d   = 1'b0;
      end
    endcase

    // IF/ID register: flush beats any load, a load beats hold/drain.
    if (flush && (state_q != FAULT)) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
      skid_d  = NOP_INSTR;
    end else if (load_fetch) begin
      valid_d    = 1'b1;
      instr_d    = imem_rdata;
      instr_pc_d = imem_addr;
    end else if (load_skid) begin
      valid_d    = 1'b1;
      instr_d    = skid_q;
      instr_pc_d = skid_pc_q;
    end else if (!stall) begin
      // Decode consumed the word and nothing new arrived.
      valid_d = 1'b0;
    end

    // A faulted stage never presents a live instruction.
    if (state_d == FAULT) begin
      valid_d = 1'b0;
    end
  end

  // State register plus all registered outputs and the skid buffer.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q     <= ISSUE;
      imem_req    <= 1'b0;
      imem_addr   <= 32'h0;
      instr_valid <= 1'b0;
      instr       <= NOP_INSTR;
      instr_pc    <= 32'h0;
      skid_q      <= NOP_INSTR;
      skid_pc_q   <= 32'h0;
      fetch_fault <= 1'b0;
    end else begin
      state_q     <= state_d;
      imem_req    <= req_d;
      imem_addr   <= addr_d;
      instr_valid <= valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
      skid_q      <= skid_d;
      skid_pc_q   <= skid_pc_d;
      fetch_fault <= fault_d;
    end
  end

  // An outstanding request keeps its address and stays asserted until ready.
  a_req_stable : assert property (@(posedge clk) disable iff (rst)
    (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr)));

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by a
// randomized run scored against an in-order instruction-stream model.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        pc_hold;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        flush;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus_4;
  logic [25:0] jump_address;
  logic [15:0] branch_offset;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  instruction_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .pc_hold         (pc_hold),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .imem_ready      (imem_ready),
    .stall           (stall),
    .flush           (flush),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus_4 (instr_pc_plus_4),
    .jump_address    (jump_address),
    .branch_offset   (branch_offset),
    .fetch_fault     (fetch_fault)
  );

  always #5 clk = ~clk;

  // Contents of the instruction memory: a fixed scramble of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  // One clock: inputs change and outputs are sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input logic [31:0] start_pc);
    @(negedge clk);
    rst = 1'b1; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    @(negedge clk);
    pc = start_pc;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; pc = 32'h0; stall = 1'b0; flush = 1'b0; imem_ready = 1'b0; imem_rdata = 32'h0;
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got %0h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h exp 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL rst_instr got %h exp 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL rst_instr_pc got %h exp 0", instr_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0h exp 0", fetch_fault); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL rst_pc_hold got %0h exp 1", pc_hold); end
    checks++; if (instr_pc_plus_4 !== 32'h4) begin errors++; $display("FAIL rst_plus4 got %h exp 4", instr_pc_plus_4); end
  endtask

  task automatic test_zero_wait();
    do_reset(32'h0);
    #1;
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL zw_hold_issue got %0h exp 1", pc_hold); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zw_req got %0h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL zw_addr got %h exp 0", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'h2002_0005;
    #1;
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL zw_hold_ready got %0h exp 0", pc_hold); end
    tick();
    imem_ready = 1'b0; pc = 32'h4; stall = 1'b1;
    #1;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL zw_valid got %0h exp 1", instr_valid); end
    checks++; if (instr !== 32'h2002_0005) begin errors++; $display("FAIL zw_instr got %h exp 20020005", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL zw_instr_pc got %h exp 0", instr_pc); end
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL zw_hold_after got %0h exp 1", pc_hold); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL zw_req_fall got %0h exp 0", imem_req); end
  endtask

  task automatic test_wait3();
    do_reset(32'h40);
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL w3_addr[%0d] got %h exp 40", i, imem_addr); end
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL w3_req[%0d] got %0h exp 1", i, imem_req); end
      checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL w3_hold[%0d] got %0h exp 1", i, pc_hold); end
      tick();
    end
    imem_ready = 1'b1; imem_rdata = 32'hDEAD_0040;
    #1;
    checks++; if (imem_addr !== 32'h40) begin errors++; $display("FAIL w3_addr_ready got %h exp 40", imem_addr); end
    checks++; if (pc_hold !== 1'b0) begin errors++; $display("FAIL w3_hold_ready got %0h exp 0", pc_hold); end
    tick();
    imem_ready = 1'b0; pc = 32'h44;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL w3_valid got %0h exp 1", instr_valid); end
    checks++; if (instr !== 32'hDEAD_0040) begin errors++; $display("FAIL w3_instr got %h exp dead0040", instr); end
    checks++; if (instr_pc !== 32'h40) begin errors++; $display("FAIL w3_instr_pc got %h exp 40", instr_pc); end
    checks++; if (instr_pc_plus_4 !== 32'h44) begin errors++; $display("FAIL w3_plus4 got %h exp 44", instr_pc_plus_4); end
  endtask

  // Continues from test_wait3: IF/ID holds 0xDEAD0040 from pc 0x40.
  task automatic test_skid();
    stall = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h44) begin errors++; $display("FAIL sk_addr got %h exp 44", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'h0800_0010;
    tick();
    imem_ready = 1'b0; pc = 32'h48;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL sk_req[%0d] got %0h exp 0", i, imem_req); end
      checks++; if (instr !== 32'hDEAD_0040) begin errors++; $display("FAIL sk_instr_held[%0d] got %h exp dead0040", i, instr); end
      checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL sk_valid_held[%0d] got %0h exp 1", i, instr_valid); end
      tick();
    end
    stall = 1'b0;
    tick();
    stall = 1'b1;
    checks++; if (instr !== 32'h0800_0010) begin errors++; $display("FAIL sk_instr got %h exp 08000010", instr); end
    checks++; if (instr_pc !== 32'h44) begin errors++; $display("FAIL sk_instr_pc got %h exp 44", instr_pc); end
    checks++; if (jump_address !== 26'h10) begin errors++; $display("FAIL sk_jump got %h exp 10", jump_address); end
    checks++; if (branch_offset !== 16'h0010) begin errors++; $display("FAIL sk_branch got %h exp 0010", branch_offset); end
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL sk_valid got %0h exp 1", instr_valid); end
  endtask

  task automatic test_flush_drop();
    do_reset(32'h100);
    tick();
    flush = 1'b1;
    #1;
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL fd_hold_flush got %0h exp 1", pc_hold); end
    tick();
    flush = 1'b0; pc = 32'h200;
    for (int i = 0; i < 2; i++) begin
      checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fd_req[%0d] got %0h exp 1", i, imem_req); end
      checks++; if (imem_addr !== 32'h100) begin errors++; $display("FAIL fd_addr[%0d] got %h exp 100", i, imem_addr); end
      tick();
    end
    imem_ready = 1'b1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL fd_hold_drop got %0h exp 1", pc_hold); end
    tick();
    imem_ready = 1'b0;
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL fd_valid got %0h exp 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL fd_instr got %h exp 0", instr); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL fd_req_new got %0h exp 1", imem_req); end
    checks++; if (imem_addr !== 32'h200) begin errors++; $display("FAIL fd_addr_new got %h exp 200", imem_addr); end
    imem_ready = 1'b1; imem_rdata = 32'h1111_2222;
    tick();
    imem_ready = 1'b0;
    checks++; if (instr !== 32'h1111_2222) begin errors++; $display("FAIL fd_instr_new got %h exp 11112222", instr); end
    checks++; if (instr_pc !== 32'h200) begin errors++; $display("FAIL fd_instr_pc_new got %h exp 200", instr_pc); end
  endtask

  task automatic test_fault();
    do_reset(32'h102);
    tick();
    pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      checks++; if (fetch_fault !== 1'b1) begin errors++; $display("FAIL ft_fault[%0d] got %0h exp 1", i, fetch_fault); end
      checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ft_req[%0d] got %0h exp 0", i, imem_req); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ft_valid[%0d] got %0h exp 0", i, instr_valid); end
      checks++; if (pc_hold !== 1'b1) begin errors++; $display("FAIL ft_hold[%0d] got %0h exp 1", i, pc_hold); end
      tick();
    end
  endtask

  task automatic test_async_reset();
    do_reset(32'h300);
    tick();
    imem_ready = 1'b1; imem_rdata = 32'h1234_5678;
    tick();
    imem_ready = 1'b0; pc = 32'h304;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL ar_valid_pre got %0h exp 1", instr_valid); end
    tick();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ar_req_pre got %0h exp 1", imem_req); end
    #2 rst = 1'b1;
    #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ar_req got %0h exp 0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ar_addr got %h exp 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL ar_valid got %0h exp 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL ar_instr got %h exp 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL ar_instr_pc got %h exp 0", instr_pc); end
    checks++; if (fetch_fault !== 1'b0) begin errors++; $display("FAIL ar_fault got %0h exp 0", fetch_fault); end
  endtask

  task automatic test_wrap();
    do_reset(32'hFFFF_FFFC);
    tick();
    imem_ready = 1'b1; imem_rdata = 32'hCAFE_F00D;
    tick();
    imem_ready = 1'b0;
    checks++; if (instr_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_instr_pc got %h exp fffffffc", instr_pc); end
    checks++; if (instr_pc_plus_4 !== 32'h0) begin errors++; $display("FAIL wr_plus4 got %h exp 0", instr_pc_plus_4); end
  endtask

  // Random memory latency, stalls and redirects. Decode must see the program
  // in strict order (pc, pc+4, ...), restarting at the target after each
  // flush, with each word equal to the memory contents at that address.
  task automatic test_random();
    logic [31:0] pc_next, exp_next, req_addr, target, tmp, w;
    logic [25:0] exp_jump;
    int          wait_cnt;
    int          accepted;
    bit          busy, dropping, exp_hold;
    tmp = $urandom;
    do_reset(tmp & 32'h0000_FFFC);
    pc_next = pc; exp_next = pc; req_addr = 32'h0; target = 32'h0;
    wait_cnt = 0; accepted = 0; busy = 1'b0; dropping = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pc = pc_next;
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      if (busy) begin
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL rnd_req_dropped cyc %0d got %0h exp 1", cyc, imem_req); busy = 1'b0; end
      end
      if (imem_req === 1'b1) begin
        if (!busy) begin
          busy = 1'b1; wait_cnt = $urandom_range(0, 3); req_addr = imem_addr;
          checks++; if (imem_addr !== pc) begin errors++; $display("FAIL rnd_issue_addr cyc %0d got %h exp %h", cyc, imem_addr, pc); end
        end else begin
          checks++; if (imem_addr !== req_addr) begin errors++; $display("FAIL rnd_addr_stable cyc %0d got %h exp %h", cyc, imem_addr, req_addr); end
        end
        if (wait_cnt == 0) begin
          imem_ready = 1'b1; imem_rdata = memf(req_addr); busy = 1'b0;
        end else begin
          wait_cnt--;
        end
      end
      stall = ($urandom_range(0, 2) == 0);
      flush = 1'b0;
      if (imem_req === 1'b1 && $urandom_range(0, 11) == 0) begin
        flush = 1'b1; tmp = $urandom; target = tmp & 32'h0000_FFFC;
      end
      #1;
      exp_hold = !(imem_ready && !flush && !dropping);
      checks++; if (pc_hold !== exp_hold) begin errors++; $display("FAIL rnd_pc_hold cyc %0d got %0h exp %0h", cyc, pc_hold, exp_hold); end
      if (imem_ready) dropping = 1'b0;
      else if (flush) dropping = 1'b1;
      if (instr_valid === 1'b1 && !stall && !flush) begin
        w = memf(exp_next); exp_jump = w[25:0];
        checks++; if (instr_pc !== exp_next) begin errors++; $display("FAIL rnd_instr_pc cyc %0d got %h exp %h", cyc, instr_pc, exp_next); end
        checks++; if (instr !== w) begin errors++; $display("FAIL rnd_instr cyc %0d got %h exp %h", cyc, instr, w); end
        checks++; if (instr_pc_plus_4 !== exp_next + 32'd4) begin errors++; $display("FAIL rnd_plus4 cyc %0d got %h exp %h", cyc, instr_pc_plus_4, exp_next + 32'd4); end
        checks++; if (jump_address !== exp_jump) begin errors++; $display("FAIL rnd_jump cyc %0d got %h exp %h", cyc, jump_address, exp_jump); end
        exp_next = exp_next + 32'd4;
        accepted++;
      end
      if (flush) exp_next = target;
      pc_next = flush ? target : (pc_hold ? pc : pc + 32'd4);
      @(negedge clk);
    end
    flush = 1'b0; stall = 1'b0; imem_ready = 1'b0;
    checks++; if (accepted < 200) begin errors++; $display("FAIL rnd_progress got %0d accepted exp >= 200", accepted); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait3();
    test_skid();
    test_flush_drop();
    test_fault();
    test_async_reset();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard stop in case a task never returns.
  initial begin
    #2_000_000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program counter and decode. Issues one instruction-memory read per PC value, captures the returned word into the IF/ID output register, and tells the program counter when to advance. It also exposes the jump and branch fields the program counter consumes. Decode stalls are absorbed by a one-entry skid buffer, and branch/jump redirects are absorbed by a flush path.

## Interface
- NOP_INSTR, 32'h0000_0000, word presented on `instr` after reset or flush
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc  in  32  current PC from program counter
- pc_hold  out  1  combinational; PC must not update while high (a taken redirect overrides it)
- imem_req  out  1  read request, registered
- imem_addr  out  32  read address, registered, word-aligned
- imem_rdata  in  32  read data, valid when imem_ready=1
- imem_ready  in  1  one-cycle completion strobe for the outstanding request
- stall  in  1  decode cannot accept a new instruction
- flush  in  1  discard all fetched/in-flight instructions (taken branch/jump/jr)
- instr_valid  out  1  IF/ID register holds a live instruction
- instr  out  32  IF/ID instruction
- instr_pc  out  32  address of `instr`
- instr_pc_plus_4  out  32  instr_pc + 4, modulo 2^32
- jump_address  out  26  instr[25:0]
- branch_offset  out  16  instr[15:0]
- fetch_fault  out  1  sticky misaligned-PC flag

## Operation
- States: ISSUE, FETCH, SKID, DROP, FAULT.
- Reset (async, immediate) sets the following:
  - state=ISSUE, imem_req=0, imem_addr=0
  - instr_valid=0, instr=NOP_INSTR, instr_pc=0
  - skid empty, fetch_fault=0
- ISSUE:
  - If pc[1:0]≠0: fetch_fault<=1, go to FAULT.
  - Otherwise: imem_addr<=pc, imem_req<=1, go to FETCH.
- FETCH:
  - imem_req stays 1 and imem_addr is held until imem_ready.
  - On imem_ready with flush=0:
    - If instr_valid=0 or stall=0: load instr/instr_pc from imem_rdata/imem_addr, set instr_valid<=1, go to ISSUE.
    - Otherwise: load skid/skid_pc, go to SKID.
    - In both cases imem_req<=0.
  - On flush without imem_ready: go to DROP.
  - On flush with imem_ready: data discarded, go to ISSUE.
- SKID: imem_req=0. When stall=0, move skid into the IF/ID register (instr_valid<=1) and go to ISSUE.
- DROP: imem_req held high at the old address. On imem_ready, discard the data and go to ISSUE. The protocol forbids dropping a request before ready.
- FAULT: imem_req=0, instr_valid=0. Terminal until rst.
- pc_hold=0 only when state=FETCH, imem_ready=1 and flush=0; pc_hold=1 otherwise. The PC therefore advances exactly once per accepted instruction.
- IF/ID register when not loading: if stall=1 it holds; if stall=0 with nothing new, instr_valid<=0 (instr/instr_pc keep their values).
- Flush (any state except FAULT): at that edge instr_valid<=0, instr<=NOP_INSTR, skid cleared. Flush has priority over stall and over any load.
- Field taps and instr_pc_plus_4 are combinational from the IF/ID register.

## Timing
- Minimum request-to-request spacing is 2 cycles (ISSUE + FETCH with 0-wait ready), so peak throughput is 1 instruction per 2 cycles.
- Latency: imem_ready at edge N gives instr_valid=1 after edge N.
- imem_addr is stable for the whole request; imem_req rises only in ISSUE→FETCH and falls only on the ready edge.
- Simultaneous stall=1 and full IF/ID at a ready edge: the word goes to skid, nothing is lost.
- Reset mid-request: imem_req drops immediately. Memory must tolerate abandonment.
- pc=0xFFFF_FFFC fetch gives instr_pc_plus_4=0x0000_0000 (wrap).

## Test plan
- Reset, pc=0x0, memory 0-wait returning 0x2002_0005 → imem_req in cycle 1, instr_valid=1 with instr=0x2002_0005, instr_pc=0, pc_hold low exactly one cycle.
- 3-wait memory at pc=0x40 → imem_addr=0x40 held for 4 cycles, pc_hold=1 throughout, instr_pc_plus_4=0x44.
- IF/ID full, stall=1 when ready returns 0x0800_0010 → SKID, imem_req=0, instr unchanged. Drop stall → instr=0x0800_0010, jump_address=0x10.
- flush asserted while request to 0x100 outstanding → DROP until ready, returned word never appears, next imem_addr equals redirected pc (e.g. 0x200).
- pc=0x102 at ISSUE → fetch_fault=1, no imem_req. Async rst mid-FETCH → all outputs at reset values before next edge.
